// File: rtl/noise_channel.sv
// Handshaked bit-error injector between the convolutional encoder and the Viterbi decoder.
// An internal Galois LFSR drives the bypass, uniform, burst and fixed-pattern error modes.
//
// state | meaning
// IDLE  | no burst in progress; in mode 2 each accepted symbol may start one
// BURST | burst active; burst_rem more accepted symbols still get flipped
module noise_channel #(
    parameter int unsigned SYM_W = 2,
    parameter int unsigned RND_W = 8,
    parameter logic [31:0] SEED  = 32'hACE1_5EED,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [RND_W-1:0] err_level,
    input  logic [7:0]       burst_len,
    input  logic             seed_load,
    input  logic [31:0]      seed,
    input  logic             cnt_clr,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [SYM_W-1:0] out_data,
    output logic [SYM_W-1:0] out_noise,
    input  logic             out_ready,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_t;

    localparam logic [31:0] TAPS = 32'h8020_0003;

    burst_state_t     burst_state;
    logic [7:0]       burst_rem;
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_step;
    logic             accept;
    logic             burst_hit;
    logic [SYM_W-1:0] mask;
    logic [2:0]       mask_pop;
    logic [CNT_W:0]   cnt_sum;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'h0);
    assign burst_hit = lfsr[RND_W-1:0] < err_level;

    always_comb begin
        mask = '0;
        case (mode)
            2'd1: begin
                for (int i = 0; i < SYM_W; i++) begin
                    mask[i] = lfsr[i*RND_W +: RND_W] < err_level;
                end
            end
            2'd2: begin
                if (burst_state == BURST || burst_hit) begin
                    mask = '1;
                end
            end
            2'd3: mask = err_level[SYM_W-1:0];
            default: mask = '0;
        endcase
    end

    always_comb begin
        mask_pop = '0;
        for (int i = 0; i < SYM_W; i++) begin
            mask_pop = mask_pop + {2'b00, mask[i]};
        end
    end

    assign cnt_sum = {1'b0, err_count} + (CNT_W+1)'(mask_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_noise <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ mask;
            out_noise <= mask;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A seed load takes priority over the step of a same-cycle accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (seed_load) begin
            lfsr <= (seed == 32'h0) ? SEED : seed;
        end else if (accept) begin
            lfsr <= lfsr_step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (cnt_clr) begin
            err_count <= '0;
        end else if (accept) begin
            err_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_state <= IDLE;
            burst_rem   <= '0;
        end else if (mode != 2'd2) begin
            burst_state <= IDLE;
            burst_rem   <= '0;
        end else if (accept) begin
            case (burst_state)
                IDLE: begin
                    if (burst_hit && burst_len > 8'd1) begin
                        burst_state <= BURST;
                        burst_rem   <= burst_len - 8'd1;
                    end
                end
                BURST: begin
                    burst_rem <= burst_rem - 8'd1;
                    if (burst_rem == 8'd1) begin
                        burst_state <= IDLE;
                    end
                end
                default: begin
                    burst_state <= IDLE;
                    burst_rem   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noise_channel.sv
// Bench for noise_channel: directed vector table, hand sequences and random traffic
// compared against a cycle-level behavioural model of the channel.
module tb_noise_channel;

    localparam logic [31:0] SEED = 32'hACE1_5EED;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [7:0]  err_level;
    logic [7:0]  burst_len;
    logic        seed_load;
    logic [31:0] seed;
    logic        cnt_clr;
    logic        in_valid;
    logic [1:0]  in_data;
    logic        out_ready;

    wire         in_ready, out_valid;
    wire [1:0]   out_data, out_noise;
    wire [15:0]  err_count;
    wire         in_ready_s, out_valid_s;
    wire [1:0]   out_data_s, out_noise_s;
    wire [3:0]   err_count_s;

    noise_channel #(.SYM_W(2), .RND_W(8), .SEED(SEED), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mode(mode), .err_level(err_level), .burst_len(burst_len),
        .seed_load(seed_load), .seed(seed), .cnt_clr(cnt_clr), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_noise(out_noise), .out_ready(out_ready), .err_count(err_count)
    );

    noise_channel #(.SYM_W(2), .RND_W(8), .SEED(SEED), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .mode(mode), .err_level(err_level), .burst_len(burst_len),
        .seed_load(seed_load), .seed(seed), .cnt_clr(cnt_clr), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready_s), .out_valid(out_valid_s), .out_data(out_data_s),
        .out_noise(out_noise_s), .out_ready(out_ready), .err_count(err_count_s)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    logic [31:0] m_lfsr;
    logic        m_valid;
    logic [1:0]  m_data, m_noise;
    int          m_cnt, m_cnt4, m_left;
    logic        m_acc;

    logic        logging = 1'b0;
    logic [1:0]  rx[$];
    logic [1:0]  tx[$];
    logic [1:0]  nz[3][256];

    typedef struct {
        logic [1:0] mode;
        logic [7:0] lvl;
        logic [1:0] din;
        logic [1:0] exp_data;
        logic [1:0] exp_noise;
        int         exp_cnt;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [1:0] model_mask();
        logic [1:0] mk;
        mk = 2'b00;
        case (mode)
            2'd1: for (int i = 0; i < 2; i++) mk[i] = ((m_lfsr >> (8*i)) & 32'hFF) < {24'h0, err_level};
            2'd2: mk = (m_left > 0 || (m_lfsr & 32'hFF) < {24'h0, err_level}) ? 2'b11 : 2'b00;
            2'd3: mk = err_level[1:0];
            default: mk = 2'b00;
        endcase
        return mk;
    endfunction

    task automatic model_reset();
        m_lfsr = SEED; m_valid = 1'b0; m_data = 2'b00; m_noise = 2'b00;
        m_cnt = 0; m_cnt4 = 0; m_left = 0; m_acc = 1'b0;
    endtask

    task automatic cycle();
        logic [1:0] mk;
        int pop;
        #1;
        chk("in_ready", in_ready, !m_valid || out_ready);
        m_acc = in_valid && (!m_valid || out_ready);
        mk = model_mask();
        if (logging && out_valid && out_ready) rx.push_back(out_data);
        if (logging && m_acc) tx.push_back(in_data);
        @(posedge clk);
        pop = int'(mk[0]) + int'(mk[1]);
        if (mode == 2'd2) begin
            if (m_acc) begin
                if (m_left > 0) m_left--;
                else if ((m_lfsr & 32'hFF) < {24'h0, err_level} && burst_len > 8'd1)
                    m_left = int'(burst_len) - 1;
            end
        end else begin
            m_left = 0;
        end
        if (m_acc) begin
            m_data = in_data ^ mk; m_noise = mk; m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (cnt_clr) begin
            m_cnt = 0; m_cnt4 = 0;
        end else if (m_acc) begin
            m_cnt  = (m_cnt + pop > 65535) ? 65535 : m_cnt + pop;
            m_cnt4 = (m_cnt4 + pop > 15) ? 15 : m_cnt4 + pop;
        end
        if (seed_load) m_lfsr = (seed == 32'h0) ? SEED : seed;
        else if (m_acc) m_lfsr = lfsr_next(m_lfsr);
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("out_noise", out_noise, m_noise);
        chk("err_count", err_count, m_cnt);
        chk("err_count_small", err_count_s, m_cnt4);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_noise", out_noise, 0);
        chk("rst_err_count", err_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run256(input int which);
        mode = 2'd1; err_level = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            in_data = 2'($urandom);
            cycle();
            nz[which][k] = out_noise;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int mism;
        int idx;
        int budget;
        logic [1:0] noise_or;

        rst = 1'b1; mode = 2'd0; err_level = 8'h00; burst_len = 8'h00; seed_load = 1'b0;
        seed = 32'h0; cnt_clr = 1'b0; in_valid = 1'b0; in_data = 2'b00; out_ready = 1'b1;
        do_reset();

        for (int i = 0; i < 4; i++) begin
            tbl[i]   = '{2'd0, 8'h00, 2'(i), 2'(i), 2'b00, 0};
            tbl[i+4] = '{2'd3, 8'h03, 2'(i), 2'(i) ^ 2'b11, 2'b11, 2*(i+1)};
        end
        for (int i = 0; i < 8; i++) begin
            mode = tbl[i].mode; err_level = tbl[i].lvl; in_data = tbl[i].din; in_valid = 1'b1;
            cycle();
            chk("tbl_data", out_data, tbl[i].exp_data);
            chk("tbl_noise", out_noise, tbl[i].exp_noise);
            chk("tbl_count", err_count, tbl[i].exp_cnt);
            chk("tbl_ready", in_ready, 1);
        end

        // zero threshold never flips, then fixed pattern saturates the 4-bit counter
        do_reset();
        mode = 2'd1; err_level = 8'h00; in_valid = 1'b1; noise_or = 2'b00;
        for (int k = 0; k < 100; k++) begin
            in_data = 2'($urandom);
            cycle();
            noise_or = noise_or | out_noise;
        end
        chk("lvl0_noise", noise_or, 0);
        chk("lvl0_count", err_count, 0);
        mode = 2'd3; err_level = 8'h03;
        for (int k = 0; k < 10; k++) begin
            in_data = 2'($urandom);
            cycle();
            chk("fixed_xor", out_data ^ 2'b11, in_data);
        end
        chk("fixed_count", err_count, 20);
        chk("small_saturate", err_count_s, 15);
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        chk("clr_wins", err_count, 0);
        chk("clr_wins_small", err_count_s, 0);
        chk("clr_accepted", out_valid, 1);

        // determinism from reset and from seed_load with zero seed
        do_reset();
        run256(0);
        chk("ff_count_range", (err_count >= 16'd500 && err_count <= 16'd512), 1);
        chk("ff_small_sat", err_count_s, 15);
        do_reset();
        run256(1);
        seed_load = 1'b1; seed = 32'h0;
        cycle();
        seed_load = 1'b0;
        run256(2);
        mism = 0;
        for (int k = 0; k < 256; k++) if (nz[0][k] !== nz[1][k]) mism++;
        chk("repeat_after_reset", mism, 0);
        mism = 0;
        for (int k = 0; k < 256; k++) if (nz[0][k] !== nz[2][k]) mism++;
        chk("repeat_after_seed0", mism, 0);

        // burst with stalls; seed 1 gives small r_0 at both burst starts
        mode = 2'd2; err_level = 8'hFF; burst_len = 8'd4; in_valid = 1'b0;
        seed_load = 1'b1; seed = 32'h1;
        cycle();
        seed_load = 1'b0;
        rx.delete(); tx.delete(); logging = 1'b1;
        idx = 0; budget = 0;
        while (idx < 8 && budget < 200) begin
            in_valid = 1'b1; in_data = 2'(idx); out_ready = budget[0];
            cycle();
            if (m_acc) idx++;
            budget++;
        end
        in_valid = 1'b0;
        while (rx.size() < 8 && budget < 400) begin
            out_ready = budget[0];
            cycle();
            budget++;
        end
        logging = 1'b0;
        chk("burst_budget", budget < 400, 1);
        chk("burst_tx", tx.size(), 8);
        chk("burst_rx", rx.size(), 8);
        for (int k = 0; k < 8 && k < rx.size() && k < tx.size(); k++)
            chk("burst_sym", rx[k], tx[k] ^ 2'b11);
        out_ready = 1'b1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            err_level = 8'($urandom);
            burst_len = 8'($urandom_range(0, 6));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = 2'($urandom);
            seed_load = ($urandom_range(0, 63) == 0);
            seed      = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
            cnt_clr   = ($urandom_range(0, 127) == 0);
            cycle();
        end
        seed_load = 1'b0; cnt_clr = 1'b0;

        // asynchronous reset while a symbol is pending
        mode = 2'd3; err_level = 8'h03; in_valid = 1'b1; out_ready = 1'b0;
        cycle();
        chk("pre_rst_valid", out_valid, 1);
        in_valid = 1'b0;
        do_reset();
        out_ready = 1'b1;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
